// File: rtl/mcpu_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory stalls and branch resolution.
// Optional build macro MCPU_CTRL_TRAP_EN sends unknown opcodes to a sticky TRAP state.
module mcpu_ctrl #(
   parameter int ALUC_W      = 4,
   parameter int MEM_TIMEOUT = 0,
   parameter int TO_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        OPcode,
   input  logic [2:0]        Fun3,
   input  logic              Fun7,
   input  logic              MIO_ready,
   input  logic              alu_zero,
   input  logic              alu_lt,
   output logic              mem_req,
   output logic              IorD,
   output logic              MemRW,
   output logic              IRWrite,
   output logic              PCWrite,
   output logic [1:0]        PCSource,
   output logic              RegWrite,
   output logic [1:0]        MemtoReg,
   output logic [1:0]        ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [2:0]        ImmSel,
   output logic [ALUC_W-1:0] ALU_Control,
   output logic [2:0]        state_o,
   output logic              bus_err,
   output logic              illegal
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
   } state_t;

   localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LOAD = 5'b00000, OP_STORE = 5'b01000;
   localparam logic [4:0] OP_BR = 5'b11000, OP_JAL = 5'b11011, OP_JALR = 5'b11001, OP_LUI = 5'b01101;
   localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SLTU = 4'b1111;
   localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
   localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

   state_t          state, state_next;
   logic [TO_W-1:0] cnt;
   logic            bus_err_q, waiting, to_hit, taken;
   logic [3:0]      alu;

   function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  alu_op = f7 ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op = 4'b1000;
         3'b010:  alu_op = ALU_SLT;
         3'b011:  alu_op = ALU_SLTU;
         3'b100:  alu_op = 4'b0011;
         3'b101:  alu_op = f7 ? 4'b1101 : 4'b0101;
         3'b110:  alu_op = 4'b0001;
         default: alu_op = 4'b0000;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         cnt       <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state <= state_next;
         if (TIMEOUT_EN && waiting && !to_hit) cnt <= cnt + TO_W'(1);
         else                                   cnt <= '0;
         if (to_hit) bus_err_q <= 1'b1;
      end
   end

   // Memory handshake: mem_req stays high in FETCH/MEM until MIO_ready is seen in the same
   // cycle; that cycle completes the access. MIO_ready in any other state is ignored.
   always_comb begin
      state_next = state;
      mem_req = 1'b0;  IorD = 1'b0;  MemRW = 1'b0;  IRWrite = 1'b0;  PCWrite = 1'b0;
      PCSource = 2'd0;  RegWrite = 1'b0;  MemtoReg = 2'd0;  ALUSrcA = 2'd0;  ALUSrcB = 2'd0;
      ImmSel = IMM_I;  alu = ALU_ADD;  illegal = 1'b0;  waiting = 1'b0;  to_hit = 1'b0;  taken = 1'b0;
      if (rst_n) begin
         case (state)
            S_FETCH: begin
               mem_req = 1'b1;
               ALUSrcA = 2'd2;
               ALUSrcB = 2'd2;
               if (MIO_ready) begin
                  IRWrite    = 1'b1;
                  PCWrite    = 1'b1;
                  state_next = S_DECODE;
               end else begin
                  waiting = 1'b1;
                  to_hit  = TIMEOUT_EN && (cnt == TO_W'(MEM_TIMEOUT - 1));
               end
            end
            S_DECODE: begin
               ALUSrcB = 2'd1;
               ImmSel  = (OPcode == OP_JAL) ? IMM_J : IMM_B;
               state_next = S_EXEC;
`ifdef MCPU_CTRL_TRAP_EN
               if (!(OPcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI}))
                  state_next = S_TRAP;
`endif
            end
            S_EXEC: begin
               state_next = S_FETCH;
               case (OPcode)
                  OP_R: begin
                     ALUSrcA = 2'd1;
                     alu     = alu_op(Fun3, Fun7);
                     state_next = S_WB;
                  end
                  OP_LOAD, OP_STORE: begin
                     ALUSrcA = 2'd1;
                     ALUSrcB = 2'd1;
                     ImmSel  = (OPcode == OP_STORE) ? IMM_S : IMM_I;
                     state_next = S_MEM;
                  end
                  OP_BR: begin
                     ALUSrcA = 2'd1;
                     alu = !Fun3[2] ? ALU_SUB : (Fun3[1] ? ALU_SLTU : ALU_SLT);
                     case (Fun3)
                        3'b000:         taken = alu_zero;
                        3'b001:         taken = !alu_zero;
                        3'b100, 3'b110: taken = alu_lt;
                        3'b101, 3'b111: taken = !alu_lt;
                        default:        taken = 1'b0;
                     endcase
                     PCWrite  = taken;
                     PCSource = taken ? 2'd1 : 2'd0;
                  end
                  OP_JAL: begin
                     RegWrite = 1'b1;
                     MemtoReg = 2'd2;
                     PCWrite  = 1'b1;
                     PCSource = 2'd1;
                  end
                  OP_JALR: begin
                     ALUSrcA  = 2'd1;
                     ALUSrcB  = 2'd1;
                     RegWrite = 1'b1;
                     MemtoReg = 2'd2;
                     PCWrite  = 1'b1;
                     PCSource = 2'd2;
                  end
                  OP_LUI: begin
                     RegWrite = 1'b1;
                     MemtoReg = 2'd3;
                     ImmSel   = IMM_U;
                  end
                  default: begin
                     // Unknown opcodes fall through here as plain addi.
                     ALUSrcA = 2'd1;
                     ALUSrcB = 2'd1;
                     if (OPcode == OP_I) alu = alu_op(Fun3, (Fun3 == 3'b101) && Fun7);
                     state_next = S_WB;
                  end
               endcase
            end
            S_MEM: begin
               mem_req = 1'b1;
               IorD    = 1'b1;
               MemRW   = (OPcode == OP_STORE);
               if (MIO_ready) begin
                  state_next = (OPcode == OP_STORE) ? S_FETCH : S_WB;
               end else begin
                  waiting = 1'b1;
                  to_hit  = TIMEOUT_EN && (cnt == TO_W'(MEM_TIMEOUT - 1));
                  if (to_hit) state_next = S_FETCH;
               end
            end
            S_WB: begin
               RegWrite   = 1'b1;
               MemtoReg   = (OPcode == OP_LOAD) ? 2'd1 : 2'd0;
               state_next = S_FETCH;
            end
`ifdef MCPU_CTRL_TRAP_EN
            S_TRAP: begin
               illegal    = 1'b1;
               state_next = S_TRAP;
            end
`endif
            default: state_next = S_FETCH;
         endcase
      end
   end

   assign ALU_Control = ALUC_W'(alu);
   assign state_o     = rst_n ? state : S_FETCH;
   assign bus_err     = bus_err_q & rst_n;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed bench for mcpu_ctrl: default instance plus a MEM_TIMEOUT=4 instance sharing the same inputs.
// Define MCPU_CTRL_TRAP_EN for both RTL and bench to exercise the TRAP path.
module tb_mcpu_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, Fun7, MIO_ready, alu_zero, alu_lt;
   logic [4:0] OPcode;
   logic [2:0] Fun3;

   logic       mem_req, IorD, MemRW, IRWrite, PCWrite, RegWrite, bus_err, illegal;
   logic [1:0] PCSource, MemtoReg, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSel, state_o;
   logic [3:0] ALU_Control;

   logic       t_mem_req, t_IorD, t_MemRW, t_IRWrite, t_PCWrite, t_RegWrite, t_bus_err, t_illegal;
   logic [1:0] t_PCSource, t_MemtoReg, t_ALUSrcA, t_ALUSrcB;
   logic [2:0] t_ImmSel, t_state_o;
   logic [3:0] t_ALU_Control;

   int n_tests = 0;
   int n_fail  = 0;

   mcpu_ctrl dut (
      .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7), .MIO_ready(MIO_ready),
      .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_req(mem_req), .IorD(IorD), .MemRW(MemRW),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .RegWrite(RegWrite),
      .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSel(ImmSel),
      .ALU_Control(ALU_Control), .state_o(state_o), .bus_err(bus_err), .illegal(illegal)
   );

   mcpu_ctrl #(.MEM_TIMEOUT(4)) dut_to (
      .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7), .MIO_ready(MIO_ready),
      .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_req(t_mem_req), .IorD(t_IorD), .MemRW(t_MemRW),
      .IRWrite(t_IRWrite), .PCWrite(t_PCWrite), .PCSource(t_PCSource), .RegWrite(t_RegWrite),
      .MemtoReg(t_MemtoReg), .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB), .ImmSel(t_ImmSel),
      .ALU_Control(t_ALU_Control), .state_o(t_state_o), .bus_err(t_bus_err), .illegal(t_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_inst(input logic [31:0] i);
      OPcode = i[6:2];
      Fun3   = i[14:12];
      Fun7   = i[30];
   endtask

   // From FETCH with ready=1, walk through DECODE and stop in EXEC.
   task automatic to_exec(input logic [31:0] i, input string tag);
      set_inst(i);
      MIO_ready = 1'b1;
      #1;
      chk({tag, " fetch"}, state_o, 0);
      tick;
      chk({tag, " decode"}, state_o, 1);
      tick;
      chk({tag, " exec"}, state_o, 2);
   endtask

   logic [31:0] r_inst [5] = '{32'h402081B3, 32'h4020D1B3, 32'h0020B1B3, 32'h002091B3, 32'h0020F1B3};
   logic [3:0]  r_alu  [5] = '{4'b0110, 4'b1101, 4'b1111, 4'b1000, 4'b0000};
   logic [31:0] i_inst [3] = '{32'hC0008093, 32'h4030D093, 32'h0030D093};
   logic [3:0]  i_alu  [3] = '{4'b0010, 4'b1101, 4'b0101};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; MIO_ready = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0;
      set_inst(32'h0);
      tick; tick;
      chk("rst state", state_o, 0);
      chk("rst mem_req", mem_req, 0);
      chk("rst bus_err", bus_err, 0);
      chk("rst illegal", illegal, 0);

      // add x3,x1,x2
      rst_n = 1'b1; MIO_ready = 1'b1; set_inst(32'h002081B3);
      #1;
      chk("add fetch state", state_o, 0);
      chk("add fetch mem_req", mem_req, 1);
      chk("add fetch IRWrite", IRWrite, 1);
      chk("add fetch PCWrite", PCWrite, 1);
      chk("add fetch RegWrite", RegWrite, 0);
      tick;
      chk("add decode state", state_o, 1);
      chk("add decode ImmSel", ImmSel, 2);
      chk("add decode RegWrite", RegWrite, 0);
      tick;
      chk("add exec state", state_o, 2);
      chk("add exec alu", ALU_Control, 4'b0010);
      chk("add exec srcA", ALUSrcA, 1);
      chk("add exec RegWrite", RegWrite, 0);
      tick;
      chk("add wb state", state_o, 4);
      chk("add wb RegWrite", RegWrite, 1);
      chk("add wb MemtoReg", MemtoReg, 0);
      tick;
      chk("add done state", state_o, 0);

      for (int k = 0; k < 5; k++) begin
         to_exec(r_inst[k], "rtype");
         chk("rtype alu", ALU_Control, r_alu[k]);
         tick;
         chk("rtype wb", RegWrite, 1);
         tick;
      end

      for (int k = 0; k < 3; k++) begin
         to_exec(i_inst[k], "itype");
         chk("itype alu", ALU_Control, i_alu[k]);
         chk("itype srcB", ALUSrcB, 1);
         tick;
         chk("itype wb", state_o, 4);
         tick;
      end

      // lw with three stall cycles in MEM
      to_exec(32'h0000A283, "lw");
      chk("lw exec ImmSel", ImmSel, 0);
      tick;
      MIO_ready = 1'b0;
      #1;
      chk("lw mem state", state_o, 3);
      chk("lw mem req", mem_req, 1);
      chk("lw mem IorD", IorD, 1);
      chk("lw mem MemRW", MemRW, 0);
      tick;
      chk("lw wait2", state_o, 3);
      tick;
      chk("lw wait3", state_o, 3);
      tick;
      chk("lw wait4", state_o, 3);
      MIO_ready = 1'b1;
      tick;
      chk("lw wb state", state_o, 4);
      chk("lw wb RegWrite", RegWrite, 1);
      chk("lw wb MemtoReg", MemtoReg, 1);
      chk("lw to bus_err", t_bus_err, 0);
      tick;
      chk("lw done", state_o, 0);

      to_exec(32'h0020A023, "sw");
      chk("sw exec ImmSel", ImmSel, 1);
      tick;
      chk("sw mem MemRW", MemRW, 1);
      chk("sw mem IorD", IorD, 1);
      tick;
      chk("sw done state", state_o, 0);

      to_exec(32'h0020C463, "blt");
      alu_lt = 1'b1; #1;
      chk("blt taken PCWrite", PCWrite, 1);
      chk("blt taken PCSource", PCSource, 1);
      chk("blt alu", ALU_Control, 4'b0111);
      tick;
      chk("blt next", state_o, 0);
      to_exec(32'h0020C463, "blt2");
      alu_lt = 1'b0; #1;
      chk("blt not taken PCWrite", PCWrite, 0);
      tick;
      chk("blt2 next", state_o, 0);

      to_exec(32'h00208463, "beq");
      alu_zero = 1'b1; #1;
      chk("beq taken PCWrite", PCWrite, 1);
      chk("beq alu", ALU_Control, 4'b0110);
      tick;
      to_exec(32'h00209463, "bne");
      chk("bne zero PCWrite", PCWrite, 0);
      tick;
      alu_zero = 1'b0;
      to_exec(32'h0020F463, "bgeu");
      chk("bgeu taken PCWrite", PCWrite, 1);
      chk("bgeu alu", ALU_Control, 4'b1111);
      tick;

      to_exec(32'h008000EF, "jal");
      chk("jal RegWrite", RegWrite, 1);
      chk("jal MemtoReg", MemtoReg, 2);
      chk("jal PCWrite", PCWrite, 1);
      chk("jal PCSource", PCSource, 1);
      tick;
      chk("jal next", state_o, 0);
      to_exec(32'h000080E7, "jalr");
      chk("jalr PCSource", PCSource, 2);
      chk("jalr MemtoReg", MemtoReg, 2);
      chk("jalr srcA", ALUSrcA, 1);
      tick;
      to_exec(32'h123450B7, "lui");
      chk("lui MemtoReg", MemtoReg, 3);
      chk("lui ImmSel", ImmSel, 4);
      chk("lui RegWrite", RegWrite, 1);
      tick;
      chk("lui next", state_o, 0);

      // unknown opcode 11111
      set_inst(32'h0000007F); #1;
      tick;
      chk("unk decode", state_o, 1);
      tick;
`ifdef MCPU_CTRL_TRAP_EN
      chk("unk trap state", state_o, 5);
      chk("unk illegal", illegal, 1);
      chk("unk RegWrite", RegWrite, 0);
      tick;
      chk("unk trap hold", state_o, 5);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      #1;
`else
      chk("unk exec state", state_o, 2);
      chk("unk alu", ALU_Control, 4'b0010);
      chk("unk illegal", illegal, 0);
      tick;
      chk("unk wb", RegWrite, 1);
      tick;
`endif
      chk("unk done", state_o, 0);

      // fetch timeout on the MEM_TIMEOUT=4 instance
      MIO_ready = 1'b0; #1;
      chk("to fetch req", t_mem_req, 1);
      tick; tick; tick;
      chk("to bus_err early", t_bus_err, 0);
      chk("to IRWrite", t_IRWrite, 0);
      tick;
      chk("to bus_err set", t_bus_err, 1);
      chk("to state", t_state_o, 0);
      chk("to default no err", bus_err, 0);
      tick;
      chk("to bus_err sticky", t_bus_err, 1);

      // reset in the middle of a MEM wait
      to_exec(32'h0000A283, "lwrst");
      tick;
      MIO_ready = 1'b0; #1;
      chk("rst mid req", mem_req, 1);
      tick;
      rst_n = 1'b0; #1;
      chk("rst cyc mem_req", mem_req, 0);
      chk("rst cyc RegWrite", RegWrite, 0);
      chk("rst cyc IRWrite", IRWrite, 0);
      chk("rst cyc state", state_o, 0);
      tick;
      chk("rst after state", state_o, 0);
      chk("rst after mem_req", mem_req, 0);
      chk("rst after to bus_err", t_bus_err, 0);
      rst_n = 1'b1; MIO_ready = 1'b1; #1;
      chk("rst release state", t_state_o, 0);
      chk("rst release bus_err", t_bus_err, 0);
      chk("rst release req", mem_req, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
